// File: rtl/tt_ffs_slot_buf.sv
// ----------------------------------------------------------------------------
// tt_ffs_slot_buf
//
// WIDTH-slot holding buffer that sits upstream of the tt_ffs priority picker.
// Producers may finish out of order. Each write is placed in the lowest-index
// free slot. One valid slot per cycle is then moved into a registered output
// stage for a single-issue consumer. Both sides use valid/ready handshakes.
//
// Configuration macro: TT_FFS_SLOT_BUF_RR_EN
//   defined   : round-robin pick, starting at a rotating pointer
//   undefined : fixed priority, where the lowest valid index always wins
//
// Ports
//   i_clk      clock
//   i_reset    synchronous reset, active-high
//   i_wr_vld   write request
//   o_wr_rdy   a free slot exists (registered state only)
//   i_wr_data  write payload
//   o_wr_slot  slot index a write in this cycle would allocate
//   o_rd_vld   output register holds an entry
//   i_rd_rdy   consumer accepts the output
//   o_rd_data  output payload
//   o_rd_slot  slot index the output came from
//   o_count    occupied slots + o_rd_vld
//   o_full     all slots valid
//   o_empty    no valid slot and no output entry
// ----------------------------------------------------------------------------
module tt_ffs_slot_buf #(
    parameter  int WIDTH      = 8,
    parameter  int DATA_WIDTH = 32,
    localparam int SIZE       = $clog2(WIDTH),
    localparam int CW         = $clog2(WIDTH + 2)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_vld,
    output logic                  o_wr_rdy,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [SIZE-1:0]       o_wr_slot,
    output logic                  o_rd_vld,
    input  logic                  i_rd_rdy,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [SIZE-1:0]       o_rd_slot,
    output logic [CW-1:0]         o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [WIDTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_data [WIDTH];
    logic                  r_rd_vld;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [SIZE-1:0]       r_rd_slot;

    logic                  w_wr_rdy;
    logic                  w_wr_fire;
    logic [SIZE-1:0]       w_wr_slot;
    logic [SIZE-1:0]       w_pick;
    logic                  w_load;
    logic [WIDTH-1:0]      w_valid_nxt;
    logic [CW-1:0]         w_count;

    assign w_wr_rdy  = ~&r_valid;
    assign w_wr_fire = i_wr_vld & w_wr_rdy;
    assign w_load    = (~r_rd_vld | i_rd_rdy) & (|r_valid);

    // Allocation: find-first-set on ~valid. The scan runs from the top index
    // down, so the lowest free index is the last one written and wins.
    always_comb begin
        w_wr_slot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_wr_slot = SIZE'(i);
        end
    end

`ifdef TT_FFS_SLOT_BUF_RR_EN
    logic [SIZE-1:0]  r_rr_ptr;
    logic [WIDTH-1:0] w_rr_mask;
    logic             w_hi_any;
    logic [SIZE-1:0]  w_pick_hi;
    logic [SIZE-1:0]  w_pick_lo;

    // Round-robin pick uses two masked find-first-set passes. The first pass
    // looks only at slots at or above the pointer. If none of those is valid,
    // the second pass wraps to the lowest valid slot overall.
    always_comb begin
        w_rr_mask = '0;
        w_pick_hi = '0;
        w_pick_lo = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_rr_mask[i] = r_valid[i] && (SIZE'(i) >= r_rr_ptr);
            if (w_rr_mask[i]) w_pick_hi = SIZE'(i);
            if (r_valid[i])   w_pick_lo = SIZE'(i);
        end
        w_hi_any = |w_rr_mask;
        w_pick   = w_hi_any ? w_pick_hi : w_pick_lo;
    end

    // The pointer moves just past the slot that was issued. WIDTH is a power
    // of two, so the SIZE-bit add wraps on its own.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_rr_ptr <= w_pick + SIZE'(1);
        end
    end
`else
    // Fixed priority: the lowest valid index always wins.
    always_comb begin
        w_pick = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_valid[i]) w_pick = SIZE'(i);
        end
    end
`endif

    // Next valid vector. A write sets a free slot and a pick clears a valid
    // slot, so the two can never touch the same bit in one cycle.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_wr_fire) w_valid_nxt[w_wr_slot] = 1'b1;
        if (w_load)    w_valid_nxt[w_pick]    = 1'b0;
    end

    // Occupancy is taken from registered state only: valid slots plus the
    // output entry.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_count = w_count + CW'(r_valid[i]);
        end
        w_count = w_count + CW'(r_rd_vld);
    end

    // Slot flags and the output stage. A load replaces the output entry.
    // Without a load, a ready consumer drains the output, which can only
    // happen once no slot is valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid   <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
            r_rd_slot <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_load) begin
                r_rd_vld  <= 1'b1;
                r_rd_data <= r_data[w_pick];
                r_rd_slot <= w_pick;
            end else if (i_rd_rdy) begin
                r_rd_vld  <= 1'b0;
            end
        end
    end

    // Payload storage does not need a reset, because the valid bits qualify
    // every entry.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) r_data[w_wr_slot] <= i_wr_data;
    end

    // A write presented while the buffer is full is dropped. This assertion
    // flags it in simulation.
    a_wr_when_full: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_wr_vld && !w_wr_rdy))
        else $error("tt_ffs_slot_buf: write dropped while full");

    assign o_wr_rdy  = w_wr_rdy;
    assign o_wr_slot = w_wr_slot;
    assign o_rd_vld  = r_rd_vld;
    assign o_rd_data = r_rd_data;
    assign o_rd_slot = r_rd_slot;
    assign o_count   = w_count;
    assign o_full    = ~w_wr_rdy;
    assign o_empty   = ~(|r_valid) & ~r_rd_vld;

endmodule

// File: tb/tb_tt_ffs_slot_buf.sv
// ----------------------------------------------------------------------------
// tb_tt_ffs_slot_buf
//
// Directed self-checking bench for tt_ffs_slot_buf with WIDTH=8 and
// DATA_WIDTH=32. Each scenario task drives its own stimulus and compares the
// outputs against hand-computed values.
//
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_tt_ffs_slot_buf;

    logic        clk;
    logic        reset;
    logic        wrVld;
    logic        wrRdy;
    logic [31:0] wrData;
    logic [2:0]  wrSlot;
    logic        rdVld;
    logic        rdRdy;
    logic [31:0] rdData;
    logic [2:0]  rdSlot;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    tt_ffs_slot_buf #(.WIDTH(8), .DATA_WIDTH(32)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_vld  (wrVld),
        .o_wr_rdy  (wrRdy),
        .i_wr_data (wrData),
        .o_wr_slot (wrSlot),
        .o_rd_vld  (rdVld),
        .i_rd_rdy  (rdRdy),
        .o_rd_data (rdData),
        .o_rd_slot (rdSlot),
        .o_count   (count),
        .o_full    (full),
        .o_empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit, so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        wrVld = 1'b0;
        rdRdy = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        wrVld  = 1'b0;
        wrData = '0;
        rdRdy  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (rdVld !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_vld: got %0b want 0", rdVld); end
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %0b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b want 0", full); end
        checks++; if (wrRdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_rdy: got %0b want 1", wrRdy); end
        checks++; if (rdData !== 32'h0 || rdSlot !== 3'd0) begin errors++; $display("[TB] FAIL reset_rd_out: got data=%0h slot=%0d want 0/0", rdData, rdSlot); end
    endtask

    task automatic test_single_write();
        rdRdy  = 1'b1;
        wrVld  = 1'b1;
        wrData = 32'hA5;
        checks++; if (wrSlot !== 3'd0) begin errors++; $display("[TB] FAIL single_wr_slot: got %0d want 0", wrSlot); end
        tick();
        wrVld = 1'b0;
        checks++; if (rdVld !== 1'b0) begin errors++; $display("[TB] FAIL single_latency_n1: got rd_vld=%0b want 0", rdVld); end
        checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL single_count_n1: got %0d want 1", count); end
        tick();
        checks++; if (rdVld !== 1'b1) begin errors++; $display("[TB] FAIL single_rd_vld_n2: got %0b want 1", rdVld); end
        checks++; if (rdData !== 32'hA5) begin errors++; $display("[TB] FAIL single_rd_data: got %0h want a5", rdData); end
        checks++; if (rdSlot !== 3'd0) begin errors++; $display("[TB] FAIL single_rd_slot: got %0d want 0", rdSlot); end
        checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_busy: got %0b want 0", empty); end
        tick();
        checks++; if (rdVld !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL single_drain: got rd_vld=%0b empty=%0b want 0/1", rdVld, empty); end
        rdRdy = 1'b0;
    endtask

    // Park one entry in the stalled output stage first, so that the next 8
    // writes land in slots 0..7 in order and fill every slot.
    task automatic test_fill();
        doReset();
        wrVld  = 1'b1;
        wrData = 32'hE0;
        tick();
        wrVld = 1'b0;
        tick();
        checks++; if (rdVld !== 1'b1) begin errors++; $display("[TB] FAIL fill_preload: got rd_vld=%0b want 1", rdVld); end
        for (int i = 0; i < 8; i++) begin
            wrVld  = 1'b1;
            wrData = 32'h100 + i;
            checks++; if (wrSlot !== 3'(i) || wrRdy !== 1'b1) begin errors++; $display("[TB] FAIL fill_slot%0d: got slot=%0d rdy=%0b want %0d/1", i, wrSlot, wrRdy, i); end
            tick();
        end
        wrVld = 1'b0;
        checks++; if (full !== 1'b1 || wrRdy !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: got full=%0b rdy=%0b want 1/0", full, wrRdy); end
        checks++; if (count !== 4'd9) begin errors++; $display("[TB] FAIL fill_count: got %0d want 9", count); end
        checks++; if (rdData !== 32'hE0) begin errors++; $display("[TB] FAIL fill_stalled_data: got %0h want e0", rdData); end
    endtask

    // A pop does not free a slot until after the edge. The write that follows
    // lands in slot 0, which was freed by that pop.
    task automatic test_write_pop_at_full();
        rdRdy = 1'b1;
        checks++; if (wrRdy !== 1'b0) begin errors++; $display("[TB] FAIL pop_same_cycle_rdy: got %0b want 0", wrRdy); end
        tick();
        rdRdy = 1'b0;
        checks++; if (rdSlot !== 3'd0 || rdData !== 32'h100) begin errors++; $display("[TB] FAIL pop_loaded: got slot=%0d data=%0h want 0/100", rdSlot, rdData); end
        checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL pop_count: got %0d want 8", count); end
        checks++; if (wrRdy !== 1'b1 || wrSlot !== 3'd0) begin errors++; $display("[TB] FAIL pop_freed: got rdy=%0b slot=%0d want 1/0", wrRdy, wrSlot); end
        wrVld  = 1'b1;
        wrData = 32'h200;
        tick();
        wrVld = 1'b0;
        checks++; if (full !== 1'b1 || count !== 4'd9) begin errors++; $display("[TB] FAIL pop_refill: got full=%0b count=%0d want 1/9", full, count); end
    endtask

    task automatic test_stall_release();
        logic [31:0] expData;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rdVld !== 1'b1 || rdData !== 32'h100 || rdSlot !== 3'd0) begin errors++; $display("[TB] FAIL stall_hold%0d: got vld=%0b data=%0h slot=%0d want 1/100/0", i, rdVld, rdData, rdSlot); end
        end
        rdRdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            expData = (k == 0) ? 32'h200 : 32'h100 + k;
            checks++; if (rdVld !== 1'b1 || rdSlot !== 3'(k) || rdData !== expData) begin errors++; $display("[TB] FAIL release%0d: got vld=%0b slot=%0d data=%0h want 1/%0d/%0h", k, rdVld, rdSlot, rdData, k, expData); end
        end
        tick();
        checks++; if (rdVld !== 1'b0 || empty !== 1'b1 || count !== 4'd0) begin errors++; $display("[TB] FAIL release_drain: got vld=%0b empty=%0b count=%0d want 0/1/0", rdVld, empty, count); end
        rdRdy = 1'b0;
    endtask

    // Shared setup: an entry is parked in the stalled output stage, and
    // slots 0..5 hold base+0..base+5.
    task automatic loadSixBehindStall(input logic [31:0] base);
        doReset();
        wrVld  = 1'b1;
        wrData = 32'hE1;
        tick();
        wrVld = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            wrVld  = 1'b1;
            wrData = base + i;
            tick();
        end
        wrVld = 1'b0;
    endtask

`ifdef TT_FFS_SLOT_BUF_RR_EN
    // The pointer is 1 after the first load, so slot 1 issues before slot 0.
    // Slot 0 is skipped until the pointer wraps.
    task automatic test_round_robin();
        int expSlots [6] = '{1, 2, 3, 4, 5, 0};
        loadSixBehindStall(32'h400);
        rdRdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                rdRdy = 1'b0;
                tick();
                checks++; if (rdSlot !== 3'd3) begin errors++; $display("[TB] FAIL rr_stall_slot: got %0d want 3", rdSlot); end
                rdRdy = 1'b1;
            end
            tick();
            checks++; if (rdVld !== 1'b1 || rdSlot !== 3'(expSlots[k]) || rdData !== 32'h400 + expSlots[k]) begin errors++; $display("[TB] FAIL rr_order%0d: got slot=%0d data=%0h want %0d", k, rdSlot, rdData, expSlots[k]); end
        end
        tick();
        checks++; if (rdVld !== 1'b0) begin errors++; $display("[TB] FAIL rr_drain: got %0b want 0", rdVld); end
        rdRdy = 1'b0;
    endtask
`else
    // Slot 0 is refilled between picks. It then issues ahead of slots 2..5.
    task automatic test_fixed_priority();
        int          expSlots [5] = '{0, 2, 3, 4, 5};
        logic [31:0] expData;
        loadSixBehindStall(32'h300);
        rdRdy = 1'b1;
        tick();
        checks++; if (rdSlot !== 3'd0 || rdData !== 32'h300) begin errors++; $display("[TB] FAIL fp_first: got slot=%0d data=%0h want 0/300", rdSlot, rdData); end
        tick();
        rdRdy = 1'b0;
        checks++; if (rdSlot !== 3'd1 || rdData !== 32'h301) begin errors++; $display("[TB] FAIL fp_second: got slot=%0d data=%0h want 1/301", rdSlot, rdData); end
        wrVld  = 1'b1;
        wrData = 32'h3AA;
        checks++; if (wrSlot !== 3'd0) begin errors++; $display("[TB] FAIL fp_refill_slot: got %0d want 0", wrSlot); end
        tick();
        wrVld = 1'b0;
        rdRdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            expData = (k == 0) ? 32'h3AA : 32'h300 + expSlots[k];
            checks++; if (rdVld !== 1'b1 || rdSlot !== 3'(expSlots[k]) || rdData !== expData) begin errors++; $display("[TB] FAIL fp_order%0d: got slot=%0d data=%0h want %0d/%0h", k, rdSlot, rdData, expSlots[k], expData); end
        end
        tick();
        checks++; if (rdVld !== 1'b0) begin errors++; $display("[TB] FAIL fp_drain: got %0b want 0", rdVld); end
        rdRdy = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        doReset();
        for (int i = 0; i < 3; i++) begin
            wrVld  = 1'b1;
            wrData = 32'h500 + i;
            tick();
        end
        wrVld = 1'b0;
        checks++; if (count !== 4'd3 || rdVld !== 1'b1) begin errors++; $display("[TB] FAIL mid_before: got count=%0d vld=%0b want 3/1", count, rdVld); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (rdVld !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || wrRdy !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset: got vld=%0b count=%0d empty=%0b rdy=%0b want 0/0/1/1", rdVld, count, empty, wrRdy); end
        wrVld  = 1'b1;
        wrData = 32'h5D;
        checks++; if (wrSlot !== 3'd0) begin errors++; $display("[TB] FAIL mid_wr_slot: got %0d want 0", wrSlot); end
        tick();
        wrVld = 1'b0;
        tick();
        checks++; if (rdVld !== 1'b1 || rdSlot !== 3'd0 || rdData !== 32'h5D) begin errors++; $display("[TB] FAIL mid_after: got vld=%0b slot=%0d data=%0h want 1/0/5d", rdVld, rdSlot, rdData); end
    endtask

    initial begin
        $display("[TB] tt_ffs_slot_buf directed tests");
        test_reset();
        test_single_write();
        test_fill();
        test_write_pop_at_full();
        test_stall_release();
`ifdef TT_FFS_SLOT_BUF_RR_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
